prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed word stream (count, hi/lo byte pairs,
// XOR checksum) and writes each 16-bit word into instruction memory.
module prog_loader #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        i_we,
  output logic [7:0]  IM_addr,
  output logic [15:0] i_dataout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] LO    = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] CHK   = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam logic [2:0] ERR   = 3'd7;

  logic [2:0]  state;
  logic [8:0]  remaining;
  logic [7:0]  checksum;
  logic [15:0] timer;
  logic        accept;
  logic        timer_expired;

  // NOTE: every output is decoded from the state register alone, so the async
  // reset pulls i_we low immediately instead of waiting for a clock edge.
  assign rx_ready = (state == COUNT) || (state == HI) || (state == LO) || (state == CHK);
  assign i_we     = (state == WRITE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign busy     = (state != IDLE) && (state != DONE) && (state != ERR);

  assign accept        = rx_valid && rx_ready;
  assign timer_expired = ({1'b0, timer} + 17'd1) >= {1'b0, TIMEOUT};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      checksum  <= '0;
      timer     <= '0;
      IM_addr   <= '0;
      i_dataout <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (load_req) begin
            state    <= COUNT;
            IM_addr  <= '0;
            checksum <= '0;
            timer    <= '0;
          end
        end

        COUNT, HI, LO, CHK: begin
          if (accept) begin
            timer <= '0;
            case (state)
              COUNT: begin
                // A count byte of zero encodes a full 256-word frame.
                remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                state     <= HI;
              end
              HI: begin
                i_dataout[15:8] <= rx_data;
                checksum        <= checksum ^ rx_data;
                state           <= LO;
              end
              LO: begin
                i_dataout[7:0] <= rx_data;
                checksum       <= checksum ^ rx_data;
                state          <= WRITE;
              end
              default: begin
                state <= (rx_data == checksum) ? DONE : ERR;
              end
            endcase
          end else if (timer_expired) begin
            state <= ERR;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        WRITE: begin
          IM_addr   <= IM_addr + 8'd1;
          remaining <= remaining - 9'd1;
          state     <= (remaining == 9'd1) ? CHK : HI;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
